// File: rtl/ysyx_25030085_pkg.sv
// Shared definitions for the load/store path, also used by decode.
//   lsu_state_t    : LSU control FSM states
//   F3_*           : RV32 funct3 width codes for loads and stores
//   lsu_misaligned : true when an op cannot be issued (bad alignment or
//                    a width code that is illegal for the op kind)
package ysyx_25030085_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo,
                                          input logic       is_store);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = addr_lo[0];
      F3_LW:   bad = |addr_lo;
      F3_LBU:  bad = is_store;
      F3_LHU:  bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational lane logic for the LSU.
//   funct3, addr_lo, is_store : latched op description
//   wdata      : right-aligned store data
//   rdata      : raw memory word from the response
//   wmask      : byte enables (zero for loads)
//   wdata_lane : store data replicated into every lane of its width
//   ld_ext     : selected byte/half/word, sign- or zero-extended
module ysyx_25030085_lsu_align
  import ysyx_25030085_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] ld_ext
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replicating the data means the memory only has to honour the mask.
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        wmask      = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: wmask = 4'b1111;
    endcase
    if (!is_store) wmask = 4'b0000;
  end

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   ld_ext = sext8(byte_sel);
      F3_LH:   ld_ext = sext16(half_sel);
      F3_LBU:  ld_ext = {24'b0, byte_sel};
      F3_LHU:  ld_ext = {16'b0, half_sel};
      default: ld_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one memory op from execute, issues at most one
// memory request, waits for its response and pulses done.
//   clk, rst                      : clock, synchronous active-high reset
//   op_valid/op_ready             : op handshake (ready only in IDLE)
//   op_load, op_store, funct3     : op kind and width code
//   addr, wdata                   : byte address, right-aligned store data
//   mem_req_valid/mem_req_ready   : request handshake
//   mem_addr, mem_wen, mem_wmask, mem_wdata : request fields (word aligned)
//   mem_resp_valid, mem_rdata     : one response per request
//   done, misalign                : completion pulse, alignment reject flag
//   ld_data                       : extended load result, held until next load
module ysyx_25030085_lsu
  import ysyx_25030085_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        misalign
);

  lsu_state_t  state, state_next;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic        misal_q;
  logic        accept;
  logic        bad_now;
  logic [3:0]  wmask;
  logic [31:0] wdata_lane;
  logic [31:0] ld_ext;

  // Asserting both kinds (or neither) is not a valid op and is not accepted.
  assign accept  = (state == ST_IDLE) & op_valid & (op_load ^ op_store);
  assign bad_now = lsu_misaligned(funct3, addr[1:0], op_store);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = bad_now ? ST_FIN : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
      ST_WAIT: if (mem_resp_valid) state_next = ST_FIN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready      = (state == ST_IDLE);
    mem_req_valid = (state == ST_REQ);
    done          = (state == ST_FIN);
    misalign      = (state == ST_FIN) & misal_q;
    mem_addr      = {addr_q[31:2], 2'b00};
    mem_wen       = store_q;
    mem_wmask     = wmask;
    mem_wdata     = wdata_lane;
  end

  // Op fields are frozen at accept so request fields stay stable while
  // execute moves on; ld_data only changes on a completed load.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= 3'b000;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      store_q  <= 1'b0;
      misal_q  <= 1'b0;
      ld_data  <= 32'b0;
    end else begin
      if (accept) begin
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
        store_q  <= op_store;
        misal_q  <= bad_now;
      end
      if ((state == ST_WAIT) && mem_resp_valid && !store_q)
        ld_data <= ld_ext;
    end
  end

  ysyx_25030085_lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .is_store   (store_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .ld_ext     (ld_ext)
  );

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Directed bench for ysyx_25030085_lsu: a table of ops with hand-computed
// request fields, latencies and load results, plus hand-written sequences
// for reset, illegal op kinds, stray responses and reset during WAIT.
module tb_ysyx_25030085_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_load = 1'b0;
  logic        op_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'b0;
  logic        done;
  logic [31:0] ld_data;
  logic        misalign;

  always #5 clk = ~clk;

  ysyx_25030085_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_load        (op_load),
    .op_store       (op_store),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .done           (done),
    .ld_data        (ld_data),
    .misalign       (misalign)
  );

  typedef struct {
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    logic        mis;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwd;
    logic [31:0] ld;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[18];

  function automatic vec_t mk(logic ld_k, logic st_k, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              int stall, logic mis, logic [31:0] maddr,
                              logic [3:0] mask, logic [31:0] mwd,
                              logic [31:0] ld_e);
    vec_t v;
    v.is_load = ld_k; v.is_store = st_k; v.f3 = f3; v.a = a; v.wd = wd;
    v.rd = rd; v.stall = stall; v.mis = mis; v.maddr = maddr;
    v.mask = mask; v.mwd = mwd; v.ld = ld_e;
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int  stall_left;
    bit  pending;
    bit  got;
    bit  seen;
    int  lat;
    stall_left = v.stall;
    pending = 0; got = 0; seen = 0; lat = 0;
    @(negedge clk);
    chk1($sformatf("v%0d op_ready before accept", idx), op_ready, 1'b1);
    op_valid = 1'b1; op_load = v.is_load; op_store = v.is_store;
    funct3 = v.f3; addr = v.a; wdata = v.wd;
    @(negedge clk);
    // Scramble the op inputs so any use of unlatched values shows up.
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
    funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h5A5A_A5A5;
      if (pending) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = v.rd;
        pending        = 0;
      end
      if (done) begin
        got = 1;
        lat = cyc;
        break;
      end
      if (mem_req_valid) begin
        seen = 1;
        chk32($sformatf("v%0d mem_addr", idx), mem_addr, v.maddr);
        chk1($sformatf("v%0d mem_wen", idx), mem_wen, v.is_store);
        if (v.is_store) begin
          chk32($sformatf("v%0d mem_wmask", idx), {28'b0, mem_wmask}, {28'b0, v.mask});
          chk32($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwd);
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          pending = 1;
        end
      end
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL v%0d done timeout: got no done, expected done within 30 cycles", idx);
    end else begin
      chk32($sformatf("v%0d latency", idx), 32'(lat), v.mis ? 32'd1 : 32'(3 + v.stall));
      chk1($sformatf("v%0d misalign", idx), misalign, v.mis);
      chk1($sformatf("v%0d op_ready in FIN", idx), op_ready, 1'b0);
      chk1($sformatf("v%0d request issued", idx), seen, !v.mis);
      chk32($sformatf("v%0d ld_data", idx), ld_data, v.ld);
    end
  endtask

  initial begin
    //           ld st f3      addr          wdata         rdata        stl mis maddr         mask     mwdata        ld_data
    tbl[0]  = mk(1, 0, 3'b000, 32'h80000003, 32'h0,        32'h80FF1234, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFF80);
    tbl[1]  = mk(1, 0, 3'b101, 32'h80000002, 32'h0,        32'hBEEF0000, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'h0000BEEF);
    tbl[2]  = mk(1, 0, 3'b001, 32'h80000002, 32'h0,        32'hBEEF0000, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFBEEF);
    tbl[3]  = mk(0, 1, 3'b000, 32'h80000001, 32'h000000AB, 32'h0,        0, 0, 32'h80000000, 4'b0010, 32'hABABABAB, 32'hFFFFBEEF);
    tbl[4]  = mk(1, 0, 3'b010, 32'h80000002, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF);
    tbl[5]  = mk(1, 0, 3'b010, 32'h80000010, 32'h0,        32'h12345678, 5, 0, 32'h80000010, 4'b0000, 32'h0,        32'h12345678);
    tbl[6]  = mk(1, 0, 3'b100, 32'h80000001, 32'h0,        32'h1234F678, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'h000000F6);
    tbl[7]  = mk(1, 0, 3'b000, 32'h80000000, 32'h0,        32'h0000007F, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'h0000007F);
    tbl[8]  = mk(0, 1, 3'b001, 32'h80000002, 32'h1234CDEF, 32'h0,        0, 0, 32'h80000000, 4'b1100, 32'hCDEFCDEF, 32'h0000007F);
    tbl[9]  = mk(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        2, 0, 32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0000007F);
    tbl[10] = mk(0, 1, 3'b001, 32'h80000003, 32'h00001111, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0000007F);
    tbl[11] = mk(0, 1, 3'b100, 32'h80000000, 32'h00002222, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0000007F);
    tbl[12] = mk(1, 0, 3'b011, 32'h80000000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0000007F);
    tbl[13] = mk(1, 0, 3'b001, 32'h80000001, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0000007F);
    tbl[14] = mk(1, 0, 3'b001, 32'h80000000, 32'h0,        32'h00008001, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFF8001);
    tbl[15] = mk(0, 1, 3'b000, 32'h80000003, 32'h123456C3, 32'h0,        0, 0, 32'h80000000, 4'b1000, 32'hC3C3C3C3, 32'hFFFF8001);
    tbl[16] = mk(1, 0, 3'b101, 32'h80000000, 32'h0,        32'h7FFF8001, 0, 0, 32'h80000000, 4'b0000, 32'h0,        32'h00008001);
    tbl[17] = mk(1, 0, 3'b010, 32'h80000008, 32'h0,        32'h89ABCDEF, 0, 0, 32'h80000008, 4'b0000, 32'h0,        32'h89ABCDEF);

    // Reset state
    repeat (2) @(negedge clk);
    chk1("reset op_ready", op_ready, 1'b1);
    chk1("reset mem_req_valid", mem_req_valid, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset misalign", misalign, 1'b0);
    chk32("reset ld_data", ld_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_op(tbl[i], i);

    // Both kinds asserted: not accepted
    @(negedge clk);
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b1; funct3 = 3'b010; addr = 32'h80000000;
    @(negedge clk);
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("both-kind op_ready", op_ready, 1'b1);
      chk1("both-kind mem_req_valid", mem_req_valid, 1'b0);
      chk1("both-kind done", done, 1'b0);
      @(negedge clk);
    end

    // Stray response in IDLE is ignored
    mem_resp_valid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk1("stray resp done", done, 1'b0);
    chk1("stray resp op_ready", op_ready, 1'b1);
    chk32("stray resp ld_data", ld_data, 32'h89ABCDEF);

    // Reset during WAIT aborts; late response after reset is ignored
    op_valid = 1'b1; op_load = 1'b1; funct3 = 3'b010; addr = 32'h80000020;
    @(negedge clk);
    op_valid = 1'b0; op_load = 1'b0;
    chk1("abort in REQ", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk1("abort in WAIT req_valid", mem_req_valid, 1'b0);
    chk1("abort in WAIT op_ready", op_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("abort done", done, 1'b0);
    chk1("abort op_ready", op_ready, 1'b1);
    chk32("abort ld_data", ld_data, 32'h0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk1("late resp done", done, 1'b0);
    chk1("late resp op_ready", op_ready, 1'b1);
    chk32("late resp ld_data", ld_data, 32'h0);

    // Recovery after abort
    run_op(tbl[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
